// File: rtl/pac_bus_fabric.sv
// pac_bus_fabric
// Memory-mapped bus fabric between the Pac-ARM core and its peripherals.
// Decodes each core request into the data-RAM window or the keyboard register
// window, forwards RAM writes combinationally, and answers every request
// (read, write or error) with a one-cycle ready pulse in the following cycle.
// The keyboard window fronts a small FIFO of scan codes with status,
// overflow and bus-error tracking.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   direc                 core byte address
//   datoOut               core write data
//   memWr, memRd          core write / read strobes (write wins if both high)
//   datoIn                read data returned to the core
//   ready                 response pulse for the previous cycle's request
//   ram_we, ram_addr,
//   ram_wdata, ram_rdata  synchronous data-RAM port (read data one cycle late)
//   key_valid, key_code   keyboard scanner offer
//   key_ready             FIFO not full
//   key_irq               FIFO non-empty
module pac_bus_fabric #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_WORDS = 512,
    parameter logic [ADDR_W-1:0] KEY_BASE  = 32'h0000_1000,
    parameter int                KEY_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            direc,
    input  logic [DATA_W-1:0]            datoOut,
    input  logic                         memWr,
    input  logic                         memRd,
    output logic [DATA_W-1:0]            datoIn,
    output logic                         ready,
    output logic                         ram_we,
    output logic [$clog2(MEM_WORDS)-1:0] ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata,
    input  logic                         key_valid,
    input  logic [7:0]                   key_code,
    output logic                         key_ready,
    output logic                         key_irq
);
    localparam int                MW        = $clog2(MEM_WORDS);
    localparam int                PW        = $clog2(KEY_DEPTH);
    localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(MEM_WORDS * 4);
    localparam logic [PW:0]       FULL_CNT  = (PW + 1)'(KEY_DEPTH);

    // Request qualification and address decode (request cycle)
    logic req, wr_req, rd_req;
    logic aligned, ram_hit, key_data_hit, key_stat_hit, key_ctrl_hit, err;

    assign req    = memRd | memWr;
    assign wr_req = memWr;
    assign rd_req = memRd & ~memWr;

    assign aligned      = (direc[1:0] == 2'b00);
    assign ram_hit      = aligned && (direc < RAM_LIMIT);
    assign key_data_hit = (direc == KEY_BASE);
    assign key_stat_hit = (direc == KEY_BASE + ADDR_W'(4));
    assign key_ctrl_hit = (direc == KEY_BASE + ADDR_W'(8));
    assign err          = req & ~(ram_hit | key_data_hit | key_stat_hit | key_ctrl_hit);

    assign ram_we    = wr_req & ram_hit;
    assign ram_addr  = direc[2 +: MW];
    assign ram_wdata = datoOut;

    // Keyboard FIFO
    logic [7:0]    fifo_mem [KEY_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop, flush;
    logic          clr_ovf, clr_err, overflow, bus_err;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign key_ready = ~full;
    assign key_irq   = ~empty;

    assign push    = key_valid & ~full;
    assign pop     = rd_req & key_data_hit & ~empty;
    assign flush   = wr_req & key_ctrl_hit & datoOut[2];
    assign clr_ovf = wr_req & key_ctrl_hit & datoOut[0];
    assign clr_err = wr_req & key_ctrl_hit & datoOut[1];

    // Storage is not reset: stale entries are unreachable once count is zero.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= key_code;
    end

    // Keyboard-window read data, selected in the request cycle
    logic [31:0]       status_word;
    logic [DATA_W-1:0] key_rdata;

    assign status_word = {12'b0, bus_err, overflow, full, empty, 8'b0, 8'(count)};

    always_comb begin
        key_rdata = '0;
        if (key_data_hit && !empty)
            key_rdata = DATA_W'(fifo_mem[rd_ptr]);
        else if (key_stat_hit)
            key_rdata = DATA_W'(status_word);
    end

    // Response stage: ready, pending RAM read flag, held read data
    logic              ram_rd_p1;
    logic [DATA_W-1:0] dat_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            bus_err   <= 1'b0;
            ready     <= 1'b0;
            ram_rd_p1 <= 1'b0;
            dat_hold  <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // Set events take priority over a coincident software clear.
            if (key_valid && full) overflow <= 1'b1;
            else if (clr_ovf)      overflow <= 1'b0;

            if (err)          bus_err <= 1'b1;
            else if (clr_err) bus_err <= 1'b0;

            ready     <= req;
            ram_rd_p1 <= rd_req & ram_hit;

            // Keyboard/error reads are captured at the request edge; a RAM
            // read is captured one edge later so the value keeps holding.
            if (rd_req && !ram_hit)
                dat_hold <= key_rdata;
            else if (ram_rd_p1)
                dat_hold <= ram_rdata;
        end
    end

    // The synchronous RAM output is already registered, so it is passed
    // straight through during its response cycle.
    assign datoIn = ram_rd_p1 ? ram_rdata : dat_hold;

endmodule

// File: tb/tb_pac_bus_fabric.sv
module tb_pac_bus_fabric;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] direc, datoOut, datoIn, ram_wdata, ram_rdata;
    logic        memWr, memRd, ready, ram_we, key_valid, key_ready, key_irq;
    logic [8:0]  ram_addr;
    logic [7:0]  key_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pac_bus_fabric dut (
        .clk(clk), .rst_n(rst_n), .direc(direc), .datoOut(datoOut),
        .memWr(memWr), .memRd(memRd), .datoIn(datoIn), .ready(ready),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .key_irq(key_irq)
    );

    // Synchronous data RAM attached to the fabric
    logic [31:0] tram [512];
    always @(posedge clk) begin
        ram_rdata <= tram[ram_addr];
        if (ram_we) tram[ram_addr] <= ram_wdata;
    end

    // Reference model state
    logic [31:0] ref_mem [512];
    logic [7:0]  q[$];
    bit          ovf, berr;
    logic [31:0] exp_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, check decode outputs before
    // the rising edge, then check the response after it.
    task automatic cyc(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit kv, input logic [7:0] kc);
        bit          req, rdo, ramhit, keyd, keys, keyc, err, full0;
        int          n;
        logic [31:0] rv;
        @(negedge clk);
        memRd = rd; memWr = wr; direc = a; datoOut = d; key_valid = kv; key_code = kc;
        req    = rd | wr;
        rdo    = rd & !wr;
        ramhit = (a[1:0] == 2'b00) && (a < 32'd2048);
        keyd   = (a == 32'h1000);
        keys   = (a == 32'h1004);
        keyc   = (a == 32'h1008);
        err    = req && !(ramhit || keyd || keys || keyc);
        #1;
        chk("ram_we", {31'b0, ram_we}, {31'b0, wr && ramhit});
        if (wr && ramhit) begin
            chk("ram_addr", {23'b0, ram_addr}, {23'b0, a[10:2]});
            chk("ram_wdata", ram_wdata, d);
        end
        n     = q.size();
        full0 = (n == 8);
        rv    = 32'h0;
        if (ramhit)    rv = ref_mem[a[10:2]];
        else if (keyd) rv = (n > 0) ? {24'b0, q[0]} : 32'h0;
        else if (keys) rv = {12'b0, berr, ovf, full0, n == 0, 8'b0, 8'(n)};
        if (rdo) exp_dat = rv;
        if (wr && ramhit) ref_mem[a[10:2]] = d;
        if (rdo && keyd && n > 0) void'(q.pop_front());
        if (wr && keyc && d[0]) ovf = 1'b0;
        if (wr && keyc && d[1]) berr = 1'b0;
        if (err) berr = 1'b1;
        if (kv && full0) ovf = 1'b1;
        if (wr && keyc && d[2]) q.delete();
        else if (kv && !full0) q.push_back(kc);
        @(posedge clk);
        #1;
        chk("ready", {31'b0, ready}, {31'b0, req});
        chk("datoIn", datoIn, exp_dat);
        chk("key_irq", {31'b0, key_irq}, {31'b0, q.size() != 0});
        chk("key_ready", {31'b0, key_ready}, {31'b0, q.size() < 8});
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 32'h0, 0, 8'h0);
    endtask

    task automatic push(input logic [7:0] kc);
        cyc(0, 0, 32'h0, 32'h0, 1, kc);
    endtask

    initial begin
        logic [31:0] addrs [12];
        rst_n = 1'b0; memRd = 0; memWr = 0; direc = 0; datoOut = 0;
        key_valid = 0; key_code = 0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
        ovf = 0; berr = 0; exp_dat = 32'h0;

        #12;
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_datoIn", datoIn, 32'h0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'h0);
        chk("rst_key_irq", {31'b0, key_irq}, 32'h0);
        chk("rst_key_ready", {31'b0, key_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // RAM write then read, back to back
        cyc(0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
        cyc(1, 0, 32'h10, 32'h0, 0, 0);
        idle();

        // Pre-load a small RAM working set including the last word
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 32'h20 + 32'(4 * i);
            cyc(0, 1, addrs[i], $urandom, 0, 0);
        end
        cyc(0, 1, 32'h7FC, $urandom, 0, 0);
        cyc(1, 0, 32'h7FC, 32'h0, 0, 0);
        cyc(1, 0, 32'h24, 32'h0, 0, 0);
        // Read and write together: write wins
        cyc(1, 1, 32'h28, $urandom, 0, 0);
        cyc(1, 0, 32'h28, 32'h0, 0, 0);
        addrs[8]  = 32'h1000;
        addrs[9]  = 32'h1004;
        addrs[10] = 32'h1008;
        addrs[11] = 32'h7FC;

        // FIFO ordering
        push(8'h1C); push(8'h32); push(8'h1C);
        cyc(1, 0, 32'h1004, 0, 0, 0);
        repeat (3) cyc(1, 0, 32'h1000, 0, 0, 0);
        cyc(1, 0, 32'h1004, 0, 0, 0);

        // Fill beyond depth, overflow and clear
        for (int i = 0; i < 9; i++) push(8'($urandom));
        cyc(1, 0, 32'h1004, 0, 0, 0);
        cyc(0, 1, 32'h1008, 32'h1, 0, 0);
        cyc(1, 0, 32'h1004, 0, 0, 0);

        // Simultaneous push/pop, then flush racing a push
        cyc(0, 1, 32'h1008, 32'h4, 0, 0);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        cyc(1, 0, 32'h1000, 0, 1, 8'($urandom));
        cyc(1, 0, 32'h1004, 0, 0, 0);
        cyc(0, 1, 32'h1008, 32'h4, 1, 8'($urandom));
        cyc(1, 0, 32'h1004, 0, 0, 0);
        // Push and pop on an empty FIFO
        cyc(1, 0, 32'h1000, 0, 1, 8'h5A);
        cyc(1, 0, 32'h1004, 0, 0, 0);
        cyc(1, 0, 32'h1000, 0, 0, 0);

        // Bus errors: misaligned read, unmapped write, out-of-RAM write
        cyc(1, 0, 32'h0802, 0, 0, 0);
        cyc(0, 1, 32'h4000, 32'h12345678, 0, 0);
        cyc(0, 1, 32'h0800, 32'h12345678, 0, 0);
        cyc(1, 0, 32'h1004, 0, 0, 0);
        cyc(0, 1, 32'h1008, 32'h2, 0, 0);
        cyc(1, 0, 32'h1004, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int          sel;
            logic [31:0] a, d;
            bit          rd, wr;
            sel = $urandom_range(0, 13);
            if (sel < 12)       a = addrs[sel];
            else if (sel == 12) a = 32'h1000 + 32'($urandom_range(1, 3));
            else                a = 32'h4000;
            rd = 1'($urandom);
            wr = 1'($urandom);
            d  = (a == 32'h1008) ? 32'($urandom_range(0, 7)) : $urandom;
            cyc(rd, wr, a, d, 1'($urandom), 8'($urandom));
        end

        // Asynchronous reset with a response in flight and five codes queued
        cyc(0, 1, 32'h1008, 32'h7, 0, 0);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        cyc(1, 0, 32'h1004, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'b0, ready}, 32'h0);
        chk("arst_datoIn", datoIn, 32'h0);
        chk("arst_key_irq", {31'b0, key_irq}, 32'h0);
        chk("arst_key_ready", {31'b0, key_ready}, 32'h1);
        q.delete(); ovf = 0; berr = 0; exp_dat = 32'h0;
        memRd = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 32'h1004, 0, 0, 0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pac_bus_fabric.md
Name: pac_bus_fabric

Overview:
- Parametrised memory-mapped bus fabric between the Pac-ARM core and its peripherals.
- Decodes the core address into a data-RAM window and a keyboard register window, and routes writes to the selected target.
- Returns registered read data with a one-cycle `ready` pulse.
- Replaces the constant keyboard word with a buffered keyboard FIFO that has status, overflow and error tracking.

Parameters:
- ADDR_W, 32, address bus width (byte addresses)
- DATA_W, 32, data bus width
- MEM_WORDS, 512, data-RAM size in words; must be a power of 2
- KEY_BASE, 32'h0000_1000, byte base address of the keyboard window; must not overlap RAM
- KEY_DEPTH, 8, keyboard FIFO depth; must be a power of 2, at least 2

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- direc  in  ADDR_W  core byte address
- datoOut  in  DATA_W  core write data
- memWr  in  1  core write strobe, one request per cycle
- memRd  in  1  core read strobe, one request per cycle
- datoIn  out  DATA_W  read data to core
- ready  out  1  response pulse for the request issued in the previous cycle
- ram_we  out  1  RAM write enable
- ram_addr  out  $clog2(MEM_WORDS)  RAM word address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; synchronous, valid the cycle after address
- key_valid  in  1  keyboard scanner offers a code
- key_code  in  8  scan code
- key_ready  out  1  FIFO not full
- key_irq  out  1  FIFO non-empty

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: datoIn=0, ready=0, ram_we=0, FIFO empty (count=0), overflow=0, bus_err=0, key_irq=0, key_ready=1.
- Request rules:
  - A request is memRd or memWr high in a cycle.
  - If both are high, the write wins and no read is performed.
  - Back-to-back requests are accepted every cycle; the fabric is fully pipelined.
- Decode (combinational, same cycle as the request):
  - Misaligned (direc[1:0]!=0): error.
  - RAM hit: direc < MEM_WORDS*4. ram_addr = direc[2 +: log2(MEM_WORDS)].
  - KEY hit: direc is KEY_BASE+0 (DATA), +4 (STATUS) or +8 (CTRL).
  - Anything else: error.
- RAM write: ram_we = memWr & RAM hit, driven combinationally in the request cycle; ram_wdata = datoOut.
- Response timing: ready is registered and goes high exactly 1 cycle after every request, for reads, writes and errors alike.
- Read data:
  - datoIn is registered and updates only in a read-response cycle; otherwise it holds its value.
  - RAM read: datoIn = ram_rdata.
  - DATA read: datoIn = {24'b0, head code}. The read pops the FIFO. Reading an empty FIFO returns 0 and pops nothing.
  - STATUS read: datoIn = {12'b0, bus_err[19], overflow[18], full[17], empty[16], 8'b0, count[7:0]}. count is zero-extended.
  - CTRL read and error read: datoIn = 0.
- Writes to the keyboard window:
  - CTRL write: bit0=1 clears overflow; bit1=1 clears bus_err; bit2=1 flushes the FIFO (count=0).
  - Writes to DATA or STATUS are ignored.
- Errors: set sticky bus_err; a write in error is discarded.
- FIFO push: key_valid & !full pushes key_code. key_valid & full drops the code and sets sticky overflow.
- Simultaneous push and pop on a non-empty FIFO: both occur, count unchanged, read returns the old head.
- Push and pop on an empty FIFO: the pop returns 0; the push lands and count becomes 1.
- Flush and push in the same cycle: flush wins and count=0.
- A CTRL clear that coincides with a new set event: the set wins.
- Pointers are log2(KEY_DEPTH) bits and wrap naturally. count has log2(KEY_DEPTH)+1 bits.
- Reset asserted mid-transaction:
  - All state returns to reset values immediately.
  - A pending ready is cancelled.
  - FIFO contents are lost.

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> ram_we=1 with ram_addr=4 in the write cycle; ready pulses each following cycle; datoIn=0xDEADBEEF one cycle after the read.
- Push codes 0x1C, 0x32, 0x1C, then read STATUS and DATA three times -> STATUS=0x0000_0003; DATA returns 0x1C, 0x32, 0x1C; a final STATUS read = 0x0001_0000 and key_irq=0.
- Push 9 codes with KEY_DEPTH=8 -> key_ready=0 after the 8th push; 9th code dropped; STATUS=0x0006_0008; CTRL write 0x1 -> overflow clears and STATUS=0x0002_0008.
- FIFO holds 3; assert key_valid and read DATA in the same cycle -> count stays 3 and the old head is returned; then a CTRL write 0x4 together with key_valid -> count=0.
- Read 0x0000_0802 (misaligned) and write 0x0000_4000 (unmapped) -> datoIn=0, ram_we stays 0, ready pulses for both; STATUS bit19=1; CTRL write 0x2 clears it.
- Drop rst_n asynchronously while a read is pending with FIFO count=5 -> ready=0, datoIn=0, count=0 and key_irq=0 without waiting for a clock edge.
